// File: rtl/mcu_slot_arbiter_if.sv
// ----------------------------------------------------------------------------
// mcu_slot_arbiter_if
//   Request/grant bundle between the MCU slot arbiter and its neighbours
//   (clock generator strobe, CPU/shifter/DMA requesters, address mux and
//   RAM cycle generator).
//
//   slot_en    one-clk32 strobe at the start of every memory slot
//   cpu_req    CPU RAM access pending, level
//   vid_req    shifter wants a video word this slot, level
//   snd_req    shifter SREQ; rising edge = one sound word wanted
//   dma_req    disk DMA word request, level
//   gnt_*      one-hot slot owner (cpu/vid/snd/ref/dma), or none
//   src_sel    0 idle, 1 cpu, 2 vid, 3 snd, 4 ref, 5 dma
//   cyc_start  one-clk32 pulse after slot_en when the slot is not idle
//   dma_slot   1 while the current slot is a DMA slot
//   snd_lost   one-clk32 pulse: sound edge arrived while one still pending
//
//   master: requester side (drives slot_en and requests)
//   slave : arbiter side (drives grants and status)
// ----------------------------------------------------------------------------
interface mcu_slot_arbiter_if;
  logic       slot_en;
  logic       cpu_req;
  logic       vid_req;
  logic       snd_req;
  logic       dma_req;
  logic       gnt_cpu;
  logic       gnt_vid;
  logic       gnt_snd;
  logic       gnt_ref;
  logic       gnt_dma;
  logic [2:0] src_sel;
  logic       cyc_start;
  logic       dma_slot;
  logic       snd_lost;

  modport master (
    output slot_en, cpu_req, vid_req, snd_req, dma_req,
    input  gnt_cpu, gnt_vid, gnt_snd, gnt_ref, gnt_dma,
    input  src_sel, cyc_start, dma_slot, snd_lost
  );

  modport slave (
    input  slot_en, cpu_req, vid_req, snd_req, dma_req,
    output gnt_cpu, gnt_vid, gnt_snd, gnt_ref, gnt_dma,
    output src_sel, cyc_start, dma_slot, snd_lost
  );
endinterface

// File: rtl/mcu_slot_arbiter.sv
// ----------------------------------------------------------------------------
// mcu_slot_arbiter
//   Schedules the shared DRAM address/data bus between CPU, video fetch,
//   DMA sound, DRAM refresh and disk DMA. Memory slots alternate CPU slot /
//   DMA slot; one grant is registered per slot on the clk32 edge where
//   slot_en is high and holds until the next slot_en.
//
//   Parameters
//     REF_INTERVAL   DMA slots between refresh requests (>=2)
//     REF_MAX_DEFER  DMA slots a pending refresh may lose before it becomes
//                    urgent and pre-empts video (>=1)
//
//   Ports
//     clk32  32 MHz system clock
//     porb   power-on reset, asynchronous, active low
//     bus    request/grant bundle (slave side), see mcu_slot_arbiter_if
// ----------------------------------------------------------------------------
module mcu_slot_arbiter #(
  parameter int unsigned REF_INTERVAL  = 64,
  parameter int unsigned REF_MAX_DEFER = 4
) (
  input  logic              clk32,
  input  logic              porb,
  mcu_slot_arbiter_if.slave bus
);

  localparam int unsigned RCW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int unsigned DCW = $clog2(REF_MAX_DEFER + 1);

  localparam logic [RCW-1:0] REF_LAST  = RCW'(REF_INTERVAL - 1);
  localparam logic [DCW-1:0] DEFER_MAX = DCW'(REF_MAX_DEFER);

  typedef enum logic {
    SLOT_CPU,
    SLOT_DMA
  } slot_e;

  typedef enum logic [2:0] {
    SRC_IDLE = 3'd0,
    SRC_CPU  = 3'd1,
    SRC_VID  = 3'd2,
    SRC_SND  = 3'd3,
    SRC_REF  = 3'd4,
    SRC_DMA  = 3'd5
  } src_e;

  slot_e          slot_q,     slot_d;
  src_e           src_q,      src_d;
  logic           cyc_q,      cyc_d;
  logic           dslot_q,    dslot_d;
  logic           lost_q,     lost_d;
  logic           snd_q;
  logic           snd_pend_q, snd_pend_d;
  logic           ref_pend_q, ref_pend_d;
  logic [RCW-1:0] ref_cnt_q,  ref_cnt_d;
  logic [DCW-1:0] defer_q,    defer_d;

  logic snd_rise;
  logic snd_clear;
  logic ref_urgent;
  logic ref_wrap;

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      slot_q     <= SLOT_CPU;
      src_q      <= SRC_IDLE;
      cyc_q      <= 1'b0;
      dslot_q    <= 1'b0;
      lost_q     <= 1'b0;
      snd_q      <= 1'b0;
      snd_pend_q <= 1'b0;
      ref_pend_q <= 1'b0;
      ref_cnt_q  <= '0;
      defer_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      src_q      <= src_d;
      cyc_q      <= cyc_d;
      dslot_q    <= dslot_d;
      lost_q     <= lost_d;
      snd_q      <= bus.snd_req;
      snd_pend_q <= snd_pend_d;
      ref_pend_q <= ref_pend_d;
      ref_cnt_q  <= ref_cnt_d;
      defer_q    <= defer_d;
    end
  end

  always_comb begin
    slot_d     = slot_q;
    src_d      = src_q;
    cyc_d      = 1'b0;
    dslot_d    = dslot_q;
    ref_pend_d = ref_pend_q;
    ref_cnt_d  = ref_cnt_q;
    defer_d    = defer_q;

    snd_rise   = bus.snd_req & ~snd_q;
    ref_urgent = ref_pend_q && (defer_q >= DEFER_MAX);
    ref_wrap   = (ref_cnt_q == REF_LAST);

    if (bus.slot_en) begin
      unique case (slot_q)
        SLOT_CPU: begin
          slot_d  = SLOT_DMA;
          dslot_d = 1'b0;
          // Disk DMA may borrow a CPU slot the CPU leaves idle.
          if (bus.cpu_req)      src_d = SRC_CPU;
          else if (bus.dma_req) src_d = SRC_DMA;
          else                  src_d = SRC_IDLE;
        end
        SLOT_DMA: begin
          slot_d  = SLOT_CPU;
          dslot_d = 1'b1;
          if (ref_urgent)       src_d = SRC_REF;
          else if (bus.vid_req) src_d = SRC_VID;
          else if (snd_pend_q)  src_d = SRC_SND;
          else if (ref_pend_q)  src_d = SRC_REF;
          else if (bus.dma_req) src_d = SRC_DMA;
          else                  src_d = SRC_IDLE;

          ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

          // A wrap is a fresh request: it survives a coincident refresh
          // grant, and when it is not granted it already counts as a
          // lost slot, just like an older pending refresh.
          if (src_d == SRC_REF) begin
            ref_pend_d = ref_wrap;
            defer_d    = '0;
          end else if (ref_pend_q || ref_wrap) begin
            ref_pend_d = 1'b1;
            if (defer_q < DEFER_MAX) defer_d = defer_q + 1'b1;
          end
        end
        default: slot_d = SLOT_CPU;
      endcase
      cyc_d = (src_d != SRC_IDLE);
    end

    // A rise coinciding with the sound grant re-arms the request rather
    // than being reported lost.
    snd_clear  = bus.slot_en && (src_d == SRC_SND);
    lost_d     = snd_rise & snd_pend_q & ~snd_clear;
    snd_pend_d = (snd_pend_q & ~snd_clear) | snd_rise;
  end

  assign bus.gnt_cpu   = (src_q == SRC_CPU);
  assign bus.gnt_vid   = (src_q == SRC_VID);
  assign bus.gnt_snd   = (src_q == SRC_SND);
  assign bus.gnt_ref   = (src_q == SRC_REF);
  assign bus.gnt_dma   = (src_q == SRC_DMA);
  assign bus.src_sel   = src_q;
  assign bus.cyc_start = cyc_q;
  assign bus.dma_slot  = dslot_q;
  assign bus.snd_lost  = lost_q;

endmodule
